// File: rtl/axi_pkg.sv
// Shared AXI3 definitions for the burst master: burst types, response
// codes, lock/cache/prot defaults, the FSM state enum and a response merge helper.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] LOCK_NORMAL = 2'b00;
    localparam logic [3:0] CACHE_NONE  = 4'b0000;
    localparam logic [2:0] PROT_NONE   = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_t;

    // Worst-of merge for per-beat read responses (higher code = more severe)
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_watchdog.sv
// Stall watchdog for the burst master: counts cycles while the master is active,
// restarts on every AXI handshake, and flags expiry at LIMIT-1.
module axi_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic srst,
    input  logic active,
    input  logic clear,
    output logic expired
);
    localparam int CW = $clog2(LIMIT) + 1;

    logic [CW-1:0] count_reg;

    assign expired = active && (count_reg == CW'(LIMIT - 1));

    // Count idle cycles of an active transaction; any progress restarts the count
    always_ff @(posedge clk) begin
        if (srst || !active || clear) begin
            count_reg <= '0;
        end else if (!expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/axi_burst_master.sv
// AXI3 burst master: one command becomes one complete AXI transaction with
// W/R beats streamed through pass-through side ports and a merged completion.
// Optional stall watchdog enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi_burst_master
    import axi_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int ID_W           = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [3:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [1:0]            cmd_burst,
    input  logic [ID_W-1:0]       cmd_id,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_strb,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_W-1:0]     rd_data,
    output logic [1:0]            rd_resp,
    output logic                  rd_last,
    output logic                  done_valid,
    output logic                  done_write,
    output logic [1:0]            done_resp,
    output logic                  busy,
    output logic                  proto_err,
    output logic                  timeout,
    output logic [ID_W-1:0]       awid,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [3:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic [1:0]            awlock,
    output logic [3:0]            awcache,
    output logic [2:0]            awprot,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ID_W-1:0]       wid,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [ID_W-1:0]       bid,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ID_W-1:0]       arid,
    output logic [ADDR_W-1:0]     araddr,
    output logic [3:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic [1:0]            arlock,
    output logic [3:0]            arcache,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [ID_W-1:0]       rid,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);
    // Largest legal AxSIZE is the full bus width
    localparam logic [2:0] SIZE_LIMIT = 3'($clog2(DATA_W / 8));

    state_t            state_reg, state_next;
    logic              write_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [3:0]        len_reg;
    logic [2:0]        size_reg;
    logic [1:0]        burst_reg;
    logic [ID_W-1:0]   id_reg;
    logic [3:0]        count_reg;
    logic [1:0]        resp_reg;
    logic              proto_err_reg;
    logic              timeout_reg;
    logic              wd_expired;

    wire aw_hs     = awvalid && awready;
    wire w_hs      = wvalid && wready;
    wire b_hs      = bready && bvalid;
    wire ar_hs     = arvalid && arready;
    wire r_hs      = rvalid && rready;
    wire last_beat = (count_reg == len_reg);

`ifdef AXI_MASTER_TIMEOUT_EN
    axi_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (aclk),
        .srst    (areset),
        .active  (state_reg != IDLE && state_reg != DONE),
        .clear   (aw_hs || w_hs || b_hs || ar_hs || r_hs),
        .expired (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    // State register, command latch, beat counter, response merge and sticky flags
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg     <= IDLE;
            write_reg     <= 1'b0;
            addr_reg      <= '0;
            len_reg       <= '0;
            size_reg      <= '0;
            burst_reg     <= '0;
            id_reg        <= '0;
            count_reg     <= '0;
            resp_reg      <= RESP_OKAY;
            proto_err_reg <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        write_reg <= cmd_write;
                        addr_reg  <= cmd_addr;
                        len_reg   <= cmd_len;
                        size_reg  <= (cmd_size > SIZE_LIMIT) ? SIZE_LIMIT : cmd_size;
                        burst_reg <= cmd_burst;
                        id_reg    <= cmd_id;
                        count_reg <= '0;
                        resp_reg  <= RESP_OKAY;
                    end
                end
                WR_DATA: begin
                    if (w_hs) count_reg <= count_reg + 1'b1;
                end
                WR_RESP: begin
                    if (bvalid) begin
                        resp_reg <= bresp;
                        if (bid != id_reg) proto_err_reg <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (r_hs) begin
                        count_reg <= count_reg + 1'b1;
                        resp_reg  <= resp_max(resp_reg, rresp);
                        if ((rlast != last_beat) || (rid != id_reg)) proto_err_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (wd_expired) begin
                timeout_reg <= 1'b1;
                resp_reg    <= RESP_SLVERR;
            end
        end
    end

    // Next-state logic; a watchdog expiry abandons the transaction via DONE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cmd_valid) state_next = cmd_write ? WR_ADDR : RD_ADDR;
            WR_ADDR: if (awready) state_next = WR_DATA;
            WR_DATA: if (w_hs && last_beat) state_next = WR_RESP;
            WR_RESP: if (bvalid) state_next = DONE;
            RD_ADDR: if (arready) state_next = RD_DATA;
            RD_DATA: if (r_hs && last_beat) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (wd_expired) state_next = DONE;
    end

    assign cmd_ready  = (state_reg == IDLE) && !areset;
    assign busy       = (state_reg != IDLE);
    assign proto_err  = proto_err_reg;
    assign timeout    = timeout_reg;
    assign done_valid = (state_reg == DONE);
    assign done_write = (state_reg == DONE) && write_reg;
    assign done_resp  = (state_reg == DONE) ? resp_reg : RESP_OKAY;

    assign awvalid = (state_reg == WR_ADDR);
    assign awid    = id_reg;
    assign awaddr  = addr_reg;
    assign awlen   = len_reg;
    assign awsize  = size_reg;
    assign awburst = burst_reg;
    assign awlock  = LOCK_NORMAL;
    assign awcache = CACHE_NONE;
    assign awprot  = PROT_NONE;

    assign arvalid = (state_reg == RD_ADDR);
    assign arid    = id_reg;
    assign araddr  = addr_reg;
    assign arlen   = len_reg;
    assign arsize  = size_reg;
    assign arburst = burst_reg;
    assign arlock  = LOCK_NORMAL;
    assign arcache = CACHE_NONE;
    assign arprot  = PROT_NONE;

    // Write and read beats pass straight through while in their data phase
    assign wvalid   = (state_reg == WR_DATA) && wr_valid;
    assign wr_ready = (state_reg == WR_DATA) && wready;
    assign wdata    = (state_reg == WR_DATA) ? wr_data : '0;
    assign wstrb    = (state_reg == WR_DATA) ? wr_strb : '0;
    assign wlast    = (state_reg == WR_DATA) && last_beat;
    assign wid      = id_reg;
    assign bready   = (state_reg == WR_RESP);

    assign rready   = (state_reg == RD_DATA) && rd_ready;
    assign rd_valid = (state_reg == RD_DATA) && rvalid;
    assign rd_data  = (state_reg == RD_DATA) ? rdata : '0;
    assign rd_resp  = (state_reg == RD_DATA) ? rresp : RESP_OKAY;
    assign rd_last  = (state_reg == RD_DATA) && rlast;

endmodule

// File: tb/tb_axi_burst_master.sv
// Self-checking bench for axi_burst_master: table of transactions run against a
// small AXI slave model, with scoreboard queues for AW/AR, W, R and completions,
// plus hand sequences for protocol error, mid-burst reset and (with
// AXI_MASTER_TIMEOUT_EN) the watchdog.
module tb_axi_burst_master;
    import axi_pkg::*;

    localparam int TO_CYC = 16;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic [2:0]  cmd_size = '0;
    logic [1:0]  cmd_burst = '0;
    logic [3:0]  cmd_id = '0;
    logic        wr_valid = 1'b0, wr_ready;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_strb = '0;
    logic        rd_valid, rd_ready = 1'b1, rd_last;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        done_valid, done_write, busy, proto_err, timeout;
    logic [1:0]  done_resp;
    logic [3:0]  awid, awlen, awcache, wid, arid, arlen, arcache;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awsize, awprot, arsize, arprot;
    logic [1:0]  awburst, awlock, arburst, arlock;
    logic        awvalid, awready = 1'b1, wlast, wvalid, wready = 1'b1;
    logic [3:0]  wstrb;
    logic [3:0]  bid = '0;
    logic [1:0]  bresp = '0;
    logic        bvalid = 1'b0, bready, arvalid, arready = 1'b1;
    logic [3:0]  rid = '0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0, rvalid = 1'b0, rready;

    always #5 aclk = ~aclk;

    axi_burst_master #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
        .cmd_burst(cmd_burst), .cmd_id(cmd_id),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_resp(rd_resp),
        .rd_last(rd_last),
        .done_valid(done_valid), .done_write(done_write), .done_resp(done_resp),
        .busy(busy), .proto_err(proto_err), .timeout(timeout),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  id;
    } axreq_t;
    typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; logic [3:0] id; } wexp_t;
    typedef struct packed { logic [31:0] data; logic [3:0] strb; } wsrc_t;
    typedef struct packed { logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id; } rbeat_t;
    typedef struct packed { logic write; logic [1:0] resp; } done_t;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  id;
        logic [31:0] data_base;  // beat i carries data_base + i*0x11
        logic [3:0]  strb;
        logic [31:0] rresp_pat;  // 2 bits per read beat, beat 0 in [1:0]
        logic [1:0]  bresp;
        logic        wr_toggle;  // offer write beats only on odd cycles
        int          rd_stall;   // cycles of rd_ready low while a beat is pending
        logic [2:0]  exp_size;
        logic [1:0]  exp_resp;
        int          exp_lat;    // command-to-done cycles, 0 = not checked
    } vec_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    axreq_t exp_a[$];
    wsrc_t  src_q[$];
    wexp_t  exp_w[$];
    rbeat_t r_src[$];
    rbeat_t exp_r[$];
    done_t  exp_done[$];

    logic        cmd_hs = 1'b0;
    logic        b_pending = 1'b0;
    logic [1:0]  b_resp_cfg = '0;
    logic [3:0]  b_id_cfg = '0;
    logic [3:0]  cur_len = '0;
    logic [31:0] cur_base = '0;
    logic [31:0] cur_pat = '0;
    logic [3:0]  cur_id = '0;
    int          cur_early = -1;
    logic        wr_toggle = 1'b0;
    int          rd_stall = 0;
    int          awready_hold = 0;
    int          accept_cyc = 0, done_cyc = 0, done_cnt = 0, w_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Observe the handshakes that the coming rising edge will complete
    task automatic monitor();
        axreq_t ea;
        wexp_t  we;
        rbeat_t rb;
        done_t  ed;
        if (!areset) begin
            if (cmd_valid && cmd_ready) begin
                cmd_hs = 1'b1;
                accept_cyc = cyc;
            end
            if (awvalid) begin
                check("aw_expected", 64'(exp_a.size() > 0), 64'd1);
                if (exp_a.size() > 0) begin
                    ea = exp_a[0];
                    check("aw_fields",
                          64'({1'b1, awaddr, awlen, awsize, awburst, awid, awlock, awcache, awprot}),
                          64'({ea.write, ea.addr, ea.len, ea.size, ea.burst, ea.id, 9'd0}));
                    if (awready) void'(exp_a.pop_front());
                end
            end
            if (arvalid) begin
                check("ar_expected", 64'(exp_a.size() > 0), 64'd1);
                if (exp_a.size() > 0) begin
                    ea = exp_a[0];
                    check("ar_fields",
                          64'({1'b0, araddr, arlen, arsize, arburst, arid, arlock, arcache, arprot}),
                          64'({ea.write, ea.addr, ea.len, ea.size, ea.burst, ea.id, 9'd0}));
                    if (arready) begin
                        void'(exp_a.pop_front());
                        for (int i = 0; i <= int'(cur_len); i++) begin
                            rb.data = cur_base + 32'(i) * 32'h11;
                            rb.resp = cur_pat[2*i +: 2];
                            rb.last = (cur_early < 0) ? (i == int'(cur_len)) : (i == cur_early);
                            rb.id   = cur_id;
                            r_src.push_back(rb);
                            exp_r.push_back(rb);
                        end
                    end
                end
            end
            if (wr_valid && wr_ready && src_q.size() > 0) void'(src_q.pop_front());
            if (wvalid && wready) begin
                w_cnt++;
                check("w_expected", 64'(exp_w.size() > 0), 64'd1);
                if (exp_w.size() > 0) begin
                    we = exp_w.pop_front();
                    check("w_beat", 64'({wdata, wstrb, wlast, wid}),
                          64'({we.data, we.strb, we.last, we.id}));
                    if (we.last) b_pending = 1'b1;
                end
            end
            if (bvalid && bready) b_pending = 1'b0;
            if (rvalid && rready && r_src.size() > 0) void'(r_src.pop_front());
            if (rd_valid && rd_ready) begin
                check("r_expected", 64'(exp_r.size() > 0), 64'd1);
                if (exp_r.size() > 0) begin
                    rb = exp_r.pop_front();
                    check("rd_beat", 64'({rd_data, rd_resp, rd_last}),
                          64'({rb.data, rb.resp, rb.last}));
                end
            end
            if (done_valid) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_expected", 64'(exp_done.size() > 0), 64'd1);
                if (exp_done.size() > 0) begin
                    ed = exp_done.pop_front();
                    check("done_fields", 64'({done_write, done_resp}), 64'({ed.write, ed.resp}));
                end
            end
        end
    endtask

    // Slave and beat-source model, applied just after the rising edge
    task automatic drive();
        wsrc_t  ws;
        rbeat_t rb;
        if (cmd_hs) begin
            cmd_valid = 1'b0;
            cmd_hs = 1'b0;
        end
        if (awready_hold > 0) begin
            awready = 1'b0;
            awready_hold--;
        end else begin
            awready = 1'b1;
        end
        arready = 1'b1;
        wready  = 1'b1;
        if (src_q.size() > 0 && (!wr_toggle || cyc[0])) begin
            ws = src_q[0];
            wr_valid = 1'b1; wr_data = ws.data; wr_strb = ws.strb;
        end else begin
            wr_valid = 1'b0; wr_data = '0; wr_strb = '0;
        end
        bvalid = b_pending; bresp = b_resp_cfg; bid = b_id_cfg;
        if (r_src.size() > 0) begin
            rb = r_src[0];
            rvalid = 1'b1; rdata = rb.data; rresp = rb.resp; rlast = rb.last; rid = rb.id;
        end else begin
            rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0;
        end
        if (rd_stall > 0 && r_src.size() > 0) begin
            rd_ready = 1'b0;
            rd_stall--;
        end else begin
            rd_ready = 1'b1;
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge aclk);
        monitor();
        @(posedge aclk);
        #1;
        drive();
    endtask

    task automatic flush_model();
        exp_a.delete(); src_q.delete(); exp_w.delete();
        r_src.delete(); exp_r.delete(); exp_done.delete();
        b_pending = 1'b0; cmd_hs = 1'b0; cmd_valid = 1'b0;
        rd_stall = 0; awready_hold = 0; cur_early = -1; wr_toggle = 1'b0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        flush_model();
        repeat (3) step();
        areset = 1'b0;
        #1;
    endtask

    task automatic start_txn(input vec_t v);
        axreq_t ea;
        done_t  ed;
        wsrc_t  ws;
        wexp_t  we;
        ea = '{write: v.write, addr: v.addr, len: v.len, size: v.exp_size, burst: v.burst, id: v.id};
        exp_a.push_back(ea);
        ed = '{write: v.write, resp: v.exp_resp};
        exp_done.push_back(ed);
        if (v.write) begin
            for (int i = 0; i <= int'(v.len); i++) begin
                ws.data = v.data_base + 32'(i) * 32'h11;
                ws.strb = v.strb;
                src_q.push_back(ws);
                we = '{data: ws.data, strb: v.strb, last: (i == int'(v.len)), id: v.id};
                exp_w.push_back(we);
            end
            b_resp_cfg = v.bresp;
            b_id_cfg   = v.id;
        end else begin
            cur_len  = v.len;
            cur_base = v.data_base;
            cur_pat  = v.rresp_pat;
            cur_id   = v.id;
        end
        wr_toggle = v.wr_toggle;
        rd_stall  = v.rd_stall;
        w_cnt     = 0;
        cmd_write = v.write; cmd_addr = v.addr; cmd_len = v.len;
        cmd_size  = v.size;  cmd_burst = v.burst; cmd_id = v.id;
        cmd_valid = 1'b1;
    endtask

    task automatic wait_done(output int lat);
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < 400 && done_cnt == d0; k++) step();
        check("done_seen", 64'(done_cnt - d0), 64'd1);
        lat = done_cyc - accept_cyc;
    endtask

    task automatic run_txn(input vec_t v);
        int lat;
        start_txn(v);
        wait_done(lat);
        if (v.exp_lat != 0) check("latency", 64'(lat), 64'(v.exp_lat));
        check("leftover", 64'(exp_a.size() + exp_w.size() + exp_r.size() + exp_done.size()), 64'd0);
    endtask

    vec_t tv[6];

    initial begin
        int prev_done;
        int lat;
        vec_t v;

        // write addr len size burst id data_base strb rresp_pat bresp toggle stall exp_size exp_resp exp_lat
        tv[0] = '{1'b1, 32'h100,  4'd0,  3'd2, BURST_INCR,  4'h3, 32'hDEADBEEF, 4'hF, 32'h0,    RESP_OKAY,   1'b0, 0, 3'd2, RESP_OKAY,   4};
        tv[1] = '{1'b0, 32'h200,  4'd3,  3'd2, BURST_INCR,  4'h5, 32'h11,       4'h0, 32'h20,   RESP_OKAY,   1'b0, 0, 3'd2, RESP_SLVERR, 0};
        tv[2] = '{1'b0, 32'h300,  4'd0,  3'd2, BURST_INCR,  4'h1, 32'hCAFE0000, 4'h0, 32'h0,    RESP_OKAY,   1'b0, 0, 3'd2, RESP_OKAY,   3};
        tv[3] = '{1'b1, 32'h1000, 4'd7,  3'd5, BURST_WRAP,  4'h9, 32'hA0000000, 4'h3, 32'h0,    RESP_SLVERR, 1'b1, 0, 3'd2, RESP_SLVERR, 0};
        tv[4] = '{1'b0, 32'h40,   4'd15, 3'd1, BURST_FIXED, 4'hF, 32'h1000,     4'h0, 32'h4000, RESP_OKAY,   1'b0, 5, 3'd1, RESP_EXOKAY, 0};
        tv[5] = '{1'b1, 32'h80,   4'd3,  3'd7, BURST_INCR,  4'h0, 32'h5,        4'hF, 32'h0,    RESP_DECERR, 1'b1, 0, 3'd2, RESP_DECERR, 0};

        // Reset values while reset is held
        areset = 1'b1;
        repeat (3) step();
        check("reset_ctrl", 64'({awvalid, wvalid, bready, arvalid, rready, cmd_ready, wr_ready,
                                 rd_valid, done_valid, proto_err, timeout, busy}), 64'd0);
        check("reset_addr", 64'({awaddr, awlen, awsize, awburst, awid}), 64'd0);
        check("reset_data", 64'({wdata, rd_data}), 64'd0);
        areset = 1'b0;
        #1;
        check("cmd_ready_after_reset", 64'({cmd_ready, busy}), 64'b10);

        // Table: each command is offered in the cycle right after the previous DONE
        for (int i = 0; i < 6; i++) begin
            prev_done = done_cyc;
            run_txn(tv[i]);
            if (i > 0) check("back_to_back_gap", 64'(accept_cyc - prev_done), 64'd1);
            $display("txn %0d: write=%0d len=%0d resp=%0h latency=%0d", i, tv[i].write, tv[i].len,
                     tv[i].exp_resp, done_cyc - accept_cyc);
        end
        check("proto_err_clean", 64'(proto_err), 64'd0);

        // Early rlast on beat 2 of a 4-beat read: flagged, still completes after beat 4
        cur_early = 1;
        run_txn(tv[1]);
        cur_early = -1;
        check("proto_err_early_rlast", 64'(proto_err), 64'd1);
        run_txn(tv[2]);
        check("proto_err_sticky", 64'(proto_err), 64'd1);
        do_reset();
        check("proto_err_cleared", 64'(proto_err), 64'd0);

        // Reset during beat 2 of an 8-beat write, with a short AW stall first
        v = tv[3];
        v.wr_toggle = 1'b0;
        awready_hold = 3;
        start_txn(v);
        for (int k = 0; k < 100 && w_cnt < 2; k++) step();
        check("reached_beat2", 64'(w_cnt), 64'd2);
        prev_done = done_cnt;
        areset = 1'b1;
        flush_model();
        step();
        check("mid_reset_idle", 64'({wvalid, busy, done_valid, awvalid}), 64'd0);
        areset = 1'b0;
        repeat (4) step();
        check("mid_reset_no_done", 64'(done_cnt - prev_done), 64'd0);
        run_txn(tv[0]);
        $display("post-reset write: latency=%0d", done_cyc - accept_cyc);

`ifdef AXI_MASTER_TIMEOUT_EN
        // AW never accepted: watchdog abandons the write with SLVERR
        v = tv[0];
        v.exp_resp = RESP_SLVERR;
        start_txn(v);
        awready_hold = 1000;
        wait_done(lat);
        check("timeout_latency", 64'(lat), 64'(TO_CYC + 1));
        check("timeout_flag", 64'({timeout, busy}), 64'b10);
        $display("timeout write: latency=%0d", lat);
        do_reset();
        check("timeout_cleared", 64'(timeout), 64'd0);
`else
        check("timeout_tied_low", 64'(timeout), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_burst_master.md
# axi_burst_master

Parametrised, synthesizable AXI3 master engine: the successor to the single-beat master bus functional model, generalised to configurable address/data/ID widths and FIXED/INCR/WRAP bursts of 1–16 beats. It turns one command into one complete AXI transaction, streams write and read beats through valid/ready side ports, and reports a merged response. It sits in block-level benches (e.g. eflash_ctrl) in place of the task-driven model, and can also drive the fabric in RTL.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; legal values are 32, 64 or 128; STRB_W = DATA_W/8
- ID_W, 4, AXI ID width
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the macro
- aclk  in  1  clock, rising edge
- areset  in  1  reset, synchronous, active-high
- cmd_valid/cmd_ready  in/out  1  command handshake
- cmd_write in 1; cmd_addr in ADDR_W; cmd_len in 4 (beats−1); cmd_size in 3; cmd_burst in 2; cmd_id in ID_W
- wr_valid in 1, wr_ready out 1, wr_data in DATA_W, wr_strb in STRB_W  (write beat stream)
- rd_valid out 1, rd_ready in 1, rd_data out DATA_W, rd_resp out 2, rd_last out 1  (read beat stream)
- done_valid out 1, done_write out 1, done_resp out 2  (completion pulse)
- busy out 1; proto_err out 1 (sticky); timeout out 1 (sticky)
- AXI AW: awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid out; awready in
- AXI W: wid, wdata, wstrb, wlast, wvalid out; wready in
- AXI B: bid, bresp, bvalid in; bready out
- AXI AR: arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid out; arready in
- AXI R: rid, rdata, rresp, rlast, rvalid in; rready out

## Operation
- States: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE. Only one transaction is outstanding at a time.
- IDLE: cmd_ready=1. A command handshake latches all cmd_* fields and moves to WR_ADDR or RD_ADDR, depending on cmd_write.
- cmd_size greater than log2(STRB_W) is clamped to log2(STRB_W). awlock, arlock and awcache/arcache are 0; awprot/arprot are 0.
- WR_ADDR: awvalid=1 with the latched fields. After the handshake, move to WR_DATA. AW always completes before any W beat.
- WR_DATA: wvalid=wr_valid, wr_ready=wready, wdata=wr_data, wstrb=wr_strb, wid=latched ID.
  - A 4-bit beat counter increments on each handshake.
  - wlast=1 when count==len. The last handshake moves to WR_RESP.
- WR_RESP: bready=1. On bvalid, capture bresp, then go to DONE. bid≠ID sets proto_err.
- RD_ADDR: arvalid=1. After the handshake, move to RD_DATA.
- RD_DATA: rready=rd_ready; rd_valid=rvalid; rd_data, rd_resp and rd_last pass through directly.
  - Each handshake increments the count and merges the response: merged = max(merged, rresp).
  - The beat with count==len moves to DONE.
  - rlast≠(count==len) sets proto_err; so does rid≠ID.
- DONE: done_valid=1 for exactly one cycle, with done_write and done_resp (bresp, or the merged rresp). Then return to IDLE.
- busy=1 in every state except IDLE.
- Reset mid-transaction: the next edge returns to IDLE with all outputs at reset values. No done pulse is issued; sticky flags clear.

## Timing
- Reset values: all *valid=0, bready=0, rready=0, wr_ready=0, cmd_ready=0 during reset and 1 after; all address/data/control outputs=0; proto_err=0, timeout=0, done_valid=0.
- Command accepted at edge N → awvalid/arvalid high from cycle N+1. All AW/AR outputs are registered and held stable until the handshake.
- The W and R paths are combinational pass-through with zero added latency. A full-throughput burst sustains 1 beat/cycle.
- Minimum single-beat write is 4 cycles from command to done_valid, with zero-wait slaves: AW, W, B, DONE.
- Minimum single-beat read is 3 cycles: AR, R, DONE.
- The next command can be accepted the cycle after DONE.

## Configuration
- AXI_MASTER_TIMEOUT_EN defined:
  - A watchdog counts cycles in any non-IDLE state and clears on every AXI handshake.
  - When it reaches TIMEOUT_CYCLES−1, timeout sets (sticky), all valids/readies drop, DONE issues with done_resp=2'b10 (SLVERR), and the FSM returns to IDLE.
- AXI_MASTER_TIMEOUT_EN undefined: the FSM waits indefinitely, timeout is tied 0, and no counter logic is present.

## Structure
- Package axi_pkg holds:
  - burst type constants (FIXED/INCR/WRAP), response codes, lock/prot constants;
  - the FSM state enum.
- axi_pkg replaces the legacy axi_defines macros.
- One sub-module: axi_watchdog (counter, clear, limit compare), instantiated only under AXI_MASTER_TIMEOUT_EN.

## Test plan
- Single write: addr 0x100, data 0xDEADBEEF, size 2, strb 0xF → one AW (awlen 0), one W with wlast=1, bresp 0 → done_valid with done_resp 0 after 4 cycles.
- INCR read, len 3, from 0x200; slave returns 0x11..0x44 with rresp 0,0,2,0 → four rd beats in order, rd_last on the 4th, done_resp 2.
- Backpressure: wr_valid toggling 1/0 and rd_ready low for 5 cycles → no beats lost or duplicated; beat count correct; AXI outputs stable while stalled.
- Slave asserts rlast on beat 2 of a len-3 read → proto_err=1 and sticky until reset; completion occurs after beat 4.
- Reset asserted mid-WR_DATA (beat 2 of 8) → next cycle IDLE, wvalid=0, no done_valid; a new command then completes normally.
- With AXI_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, awready held low → timeout=1 after 16 cycles, done_resp 2'b10, FSM back in IDLE.
